// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: drains bytes from the UART receiver and recognises host command frames
// (SYNC, CMD, LEN, payload, XOR checksum). Each good frame is held for the capture controller
// until it is acknowledged.
// Optional feature: define UART_CMD_PARSER_TIMEOUT_EN to build the inter-byte timeout counter;
// without it err_timeout is tied low and a stalled partial frame waits indefinitely.
module uart_cmd_parser #(
  parameter int unsigned MAX_LEN   = 8,
  parameter logic [7:0]  SYNC_BYTE = 8'hAA,
  parameter logic [15:0] TIMEOUT   = 16'd4096
) (
  input  logic       rxclk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_empty,
  output logic       uld_rx_data,
  output logic       cmd_valid,
  input  logic       cmd_ack,
  output logic [7:0] cmd_code,
  output logic [3:0] cmd_len,
  input  logic [3:0] pld_raddr,
  output logic [7:0] pld_rdata,
  output logic       err_chk,
  output logic       err_len,
  output logic       err_timeout
);

  localparam logic [3:0] MaxLen4 = 4'(MAX_LEN);
  localparam logic [7:0] MaxLen8 = 8'(MAX_LEN);

  typedef enum logic [1:0] {FIdle, FUld, FCap} fetch_e;
  typedef enum logic [2:0] {StHunt, StCmd, StLen, StData, StChk, StHold} main_e;

  fetch_e      fstate_q, fstate_d;
  main_e       state_q, state_d;
  logic        uld_q, uld_d;
  logic [7:0]  chk_q, chk_d;
  logic [7:0]  code_q, code_d;
  logic [3:0]  len_q, len_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  cmd_code_q, cmd_code_d;
  logic [3:0]  cmd_len_q, cmd_len_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        err_chk_q, err_chk_d;
  logic        err_len_q, err_len_d;
  logic        pld_we;
  logic        byte_vld;
  // Entries at or beyond MAX_LEN are never written and stay zero.
  logic [7:0]  payload_q [16];

  // A fetched byte is presented to the main FSM in F_CAP.
  assign byte_vld = (fstate_q == FCap);

  // Fetch sub-FSM: no fetch may start while a frame is held.
  always_comb begin
    fstate_d = fstate_q;
    unique case (fstate_q)
      FIdle:   if (!rx_empty && (state_q != StHold)) fstate_d = FUld;
      FUld:    fstate_d = FCap;
      FCap:    fstate_d = FIdle;
      default: fstate_d = FIdle;
    endcase
    uld_d = (fstate_d == FUld);
  end

`ifdef UART_CMD_PARSER_TIMEOUT_EN
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        tmo_active, tmo_fire;
  logic        err_timeout_q;

  assign tmo_active = (state_q == StCmd) || (state_q == StLen) ||
                      (state_q == StData) || (state_q == StChk);
  assign tmo_fire   = tmo_active && !byte_vld && (tmo_cnt_q == TIMEOUT - 16'd1);
  // Counter restarts on every consumed byte; entry into CMD is itself a consumed byte.
  assign tmo_cnt_d  = (!tmo_active || byte_vld || tmo_fire) ? 16'd0 : tmo_cnt_q + 16'd1;

  // Inter-byte timeout counter and its error pulse.
  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      tmo_cnt_q     <= 16'd0;
      err_timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      err_timeout_q <= tmo_fire;
    end
  end
  assign err_timeout = err_timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign err_timeout    = 1'b0;
`endif

  // Main frame FSM and datapath next-state.
  always_comb begin
    state_d     = state_q;
    chk_d       = chk_q;
    code_d      = code_q;
    len_d       = len_q;
    idx_d       = idx_q;
    cmd_code_d  = cmd_code_q;
    cmd_len_d   = cmd_len_q;
    cmd_valid_d = cmd_valid_q;
    err_chk_d   = 1'b0;
    err_len_d   = 1'b0;
    pld_we      = 1'b0;
    unique case (state_q)
      StHunt: if (byte_vld && (rx_data == SYNC_BYTE)) state_d = StCmd;
      StCmd: if (byte_vld) begin
        code_d  = rx_data;
        chk_d   = rx_data;
        state_d = StLen;
      end
      StLen: if (byte_vld) begin
        chk_d = chk_q ^ rx_data;
        len_d = rx_data[3:0];
        idx_d = 4'd0;
        if (rx_data > MaxLen8) begin
          err_len_d = 1'b1;
          state_d   = StHunt;
        end else if (rx_data == 8'd0) begin
          state_d = StChk;
        end else begin
          state_d = StData;
        end
      end
      StData: if (byte_vld) begin
        pld_we = 1'b1;
        chk_d  = chk_q ^ rx_data;
        idx_d  = idx_q + 4'd1;
        if ((idx_q + 4'd1) == len_q) state_d = StChk;
      end
      StChk: if (byte_vld) begin
        if (rx_data == chk_q) begin
          cmd_code_d  = code_q;
          cmd_len_d   = len_q;
          cmd_valid_d = 1'b1;
          state_d     = StHold;
        end else begin
          err_chk_d = 1'b1;
          state_d   = StHunt;
        end
      end
      StHold: if (cmd_ack) begin
        cmd_valid_d = 1'b0;
        state_d     = StHunt;
      end
      default: state_d = StHunt;
    endcase
`ifdef UART_CMD_PARSER_TIMEOUT_EN
    if (tmo_fire) state_d = StHunt;
`endif
  end

  // State and output registers.
  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      fstate_q    <= FIdle;
      state_q     <= StHunt;
      uld_q       <= 1'b0;
      chk_q       <= 8'd0;
      code_q      <= 8'd0;
      len_q       <= 4'd0;
      idx_q       <= 4'd0;
      cmd_code_q  <= 8'd0;
      cmd_len_q   <= 4'd0;
      cmd_valid_q <= 1'b0;
      err_chk_q   <= 1'b0;
      err_len_q   <= 1'b0;
    end else begin
      fstate_q    <= fstate_d;
      state_q     <= state_d;
      uld_q       <= uld_d;
      chk_q       <= chk_d;
      code_q      <= code_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      cmd_code_q  <= cmd_code_d;
      cmd_len_q   <= cmd_len_d;
      cmd_valid_q <= cmd_valid_d;
      err_chk_q   <= err_chk_d;
      err_len_q   <= err_len_d;
    end
  end

  // Payload storage; only written while a frame is being received, so stable in HOLD.
  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) payload_q[i] <= 8'd0;
    end else if (pld_we && (idx_q < MaxLen4)) begin
      payload_q[idx_q] <= rx_data;
    end
  end

  assign pld_rdata   = (pld_raddr < MaxLen4) ? payload_q[pld_raddr] : 8'd0;
  assign uld_rx_data = uld_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_code    = cmd_code_q;
  assign cmd_len     = cmd_len_q;
  assign err_chk     = err_chk_q;
  assign err_len     = err_len_q;

endmodule
